// File: rtl/clkswitch_req.sv
// clkswitch_req: sequencer for a glitch-free HS/LS CPU clock switch.
// Drives hsclk_sel to the switch and waits for the synchronised acknowledges.
// It also holds a pending divider code, applied only while running on LS.
module clkswitch_req #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DWELL       = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       hsclk_in,
  input  logic       rst_b,
  input  logic       ls_req,
  input  logic       div_wr,
  input  logic [1:0] div_wdata,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       switching,
  output logic       timeout_err,
  output logic [7:0] switch_cnt
);

  localparam logic [1:0] HS_RUN = 2'd0;
  localparam logic [1:0] TO_LS  = 2'd1;
  localparam logic [1:0] LS_RUN = 2'd2;
  localparam logic [1:0] TO_HS  = 2'd3;

  localparam logic [7:0] DWELL_C   = 8'(DWELL);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hs_s;
  logic                   ls_s;

  logic [1:0] state, state_nxt;
  logic [7:0] dwell_cnt, dwell_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [7:0] cnt_nxt;
  logic       err_nxt;
  logic       sel_nxt;
  logic       sw_nxt;
  logic [1:0] div_pend;

  // Acknowledge synchronisers; the last stage is the only one used by the FSM.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      hs_sync <= '0;
      ls_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  assign hs_s = hs_sync[SYNC_STAGES-1];
  assign ls_s = ls_sync[SYNC_STAGES-1];

  // Next-state, counter and error-flag decisions for the switch sequencer.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell_cnt;
    wait_nxt  = wait_cnt;
    cnt_nxt   = switch_cnt;
    err_nxt   = timeout_err;
    case (state)
      HS_RUN: begin
        if (ls_req) begin
          state_nxt = TO_LS;
          wait_nxt  = '0;
        end
      end
      TO_LS: begin
        if (ls_s && !hs_s) begin
          state_nxt = LS_RUN;
          dwell_nxt = '0;
          if (switch_cnt != 8'hFF) cnt_nxt = switch_cnt + 8'd1;
        end else if (wait_cnt == TIMEOUT_C) begin
          // Already requesting LS: flag it and keep waiting with the count frozen.
          err_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      LS_RUN: begin
        if (!ls_req && (dwell_cnt == DWELL_C)) begin
          state_nxt = TO_HS;
          wait_nxt  = '0;
        end else if (dwell_cnt != DWELL_C) begin
          dwell_nxt = dwell_cnt + 8'd1;
        end
      end
      TO_HS: begin
        if (hs_s && !ls_s) begin
          state_nxt = HS_RUN;
        end else if (wait_cnt == TIMEOUT_C) begin
          // HS never acknowledged: fall back towards low speed.
          err_nxt   = 1'b1;
          state_nxt = TO_LS;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = LS_RUN;
        dwell_nxt = '0;
      end
    endcase
    sel_nxt = (state_nxt == TO_HS) || (state_nxt == HS_RUN);
    sw_nxt  = (state_nxt == TO_HS) || (state_nxt == TO_LS);
  end

  // State and registered outputs, updated together so hsclk_sel cannot glitch.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state       <= LS_RUN;
      dwell_cnt   <= '0;
      wait_cnt    <= '0;
      switch_cnt  <= '0;
      timeout_err <= 1'b0;
      hsclk_sel   <= 1'b0;
      switching   <= 1'b0;
    end else begin
      state       <= state_nxt;
      dwell_cnt   <= dwell_nxt;
      wait_cnt    <= wait_nxt;
      switch_cnt  <= cnt_nxt;
      timeout_err <= err_nxt;
      hsclk_sel   <= sel_nxt;
      switching   <= sw_nxt;
    end
  end

  // Divider: writes land in the pending register and reach the switch only
  // on cycles that start in LS_RUN, so a write on the exit cycle waits.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      div_pend       <= '0;
      cpuclk_div_sel <= '0;
    end else begin
      if (div_wr) div_pend <= div_wdata;
      if (state == LS_RUN) cpuclk_div_sel <= div_pend;
    end
  end

endmodule

// File: doc/clkswitch_req.md
CLKSWITCH_REQ -- requirements
Module: clkswitch_req

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchroniser depth for the hsclk_selected and lsclk_selected acknowledges (legal range 2..4).
REQ-002 Parameter DWELL, default 4, sets the minimum number of hsclk_in cycles spent in LS_RUN before a return to high speed (legal range 1..255).
REQ-003 Parameter TIMEOUT, default 255, sets the maximum number of hsclk_in cycles to wait for an acknowledge (legal range 1..255).
REQ-004 hsclk_in  input  1  free-running fast oscillator; the single clock; all logic on posedge.
REQ-005 rst_b  input  1  reset, asynchronous assert, active-low.
REQ-006 ls_req  input  1  level, synchronous to hsclk_in; high means the pending access needs the low-speed clock.
REQ-007 div_wr  input  1  single-cycle strobe that loads div_wdata into the pending divider register.
REQ-008 div_wdata  input  2  requested CPU clock divider code.
REQ-009 hsclk_selected  input  1  asynchronous acknowledge from the clock switch that the HS clock is driving the CPU.
REQ-010 lsclk_selected  input  1  asynchronous acknowledge from the clock switch that the LS clock is selected.
REQ-011 hsclk_sel  output  1  registered request to the clock switch: 1 selects HS, 0 selects LS.
REQ-012 cpuclk_div_sel  output  2  registered divider code driven to the clock switch.
REQ-013 switching  output  1  high while the FSM is in TO_LS or TO_HS.
REQ-014 timeout_err  output  1  sticky flag recording an acknowledge timeout.
REQ-015 switch_cnt  output  8  saturating count of completed HS-to-LS transitions.

Function
REQ-016 Each acknowledge input SHALL pass through a SYNC_STAGES flop chain before use; hs_s and ls_s denote the synchronised values.
REQ-017 The FSM SHALL have four states: HS_RUN, TO_LS, LS_RUN and TO_HS.
REQ-018 hsclk_sel SHALL be 1 in TO_HS and HS_RUN, and 0 in TO_LS and LS_RUN; it is registered with the state, so there are no glitches.
REQ-019 In LS_RUN, the dwell counter SHALL clear on entry and increment each cycle, saturating at DWELL.
REQ-020 LS_RUN SHALL move to TO_HS when ls_req=0 and the dwell counter equals DWELL.
REQ-021 TO_HS SHALL move to HS_RUN when hs_s=1 and ls_s=0.
REQ-022 TO_HS SHALL ignore ls_req and SHALL NOT abort; an ls_req that arrives during TO_HS is served from HS_RUN after arrival.
REQ-023 HS_RUN SHALL move to TO_LS on the first cycle that ls_req=1.
REQ-024 TO_LS SHALL move to LS_RUN when ls_s=1 and hs_s=0; switch_cnt increments on that transition and saturates at 255.
REQ-025 A wait counter SHALL clear on entry to TO_LS or TO_HS and increment each cycle spent there.
REQ-026 If the wait counter reaches TIMEOUT in TO_HS, the FSM SHALL set timeout_err and move to TO_LS, so the failure falls back to low speed.
REQ-027 If the wait counter reaches TIMEOUT in TO_LS, the FSM SHALL set timeout_err, hold the counter and remain in TO_LS; hsclk_sel is already 0.
REQ-028 timeout_err SHALL clear only on reset.
REQ-029 div_wr SHALL load div_wdata into the pending divider register; on simultaneous writes the last write wins, and the code 2'b11 is stored unchanged.
REQ-030 cpuclk_div_sel SHALL take the pending value only on cycles when the state is LS_RUN, so it never changes while HS drives the CPU.
REQ-031 In LS_RUN, a write SHALL be visible on cpuclk_div_sel 2 cycles after the div_wr cycle.
REQ-032 A div_wr in the same cycle that the FSM leaves LS_RUN SHALL be deferred to the next LS_RUN.
REQ-033 A div_wr issued in any other state SHALL be applied on the next entry to LS_RUN.

Reset
REQ-034 During reset (rst_b=0), all outputs SHALL be held at their reset values: state=LS_RUN, hsclk_sel=0, cpuclk_div_sel=2'b00, pending divider=2'b00, switching=0, timeout_err=0, switch_cnt=0, dwell counter=0, wait counter=0, synchronisers=0.
REQ-035 Reset asserted in any state, including mid-switch, SHALL force all of the above immediately, without waiting for hsclk_in.
REQ-036 After deassertion, the first transition SHALL be no earlier than DWELL cycles.

Verification
REQ-037 Reset release with ls_req=0, and hsclk_selected rising 3 cycles after hsclk_sel (defaults) -> hsclk_sel=1 at cycle 5; HS_RUN reached 2 cycles after the ack.
REQ-038 In HS_RUN, pulse ls_req=1, with lsclk_selected=1 and hsclk_selected=0 after 5 cycles -> hsclk_sel=0 next cycle, switching high through the ack, switch_cnt 0->1.
REQ-039 Hold hsclk_selected=0 in TO_HS for 255 cycles -> timeout_err=1, state TO_LS, hsclk_sel=0, and a later ls ack reaches LS_RUN.
REQ-040 div_wr=1 with div_wdata=2'b10 in HS_RUN -> cpuclk_div_sel stays 2'b00 until LS_RUN, then becomes 2'b10; a write in LS_RUN appears 2 cycles later.
REQ-041 Perform 300 HS-to-LS round trips -> switch_cnt saturates at 255.
REQ-042 Assert rst_b=0 mid-TO_LS -> all outputs at reset values within the same cycle; no switch_cnt increment.
